// File: rtl/stream_capture_slave.sv
`default_nettype none
// ============================================================================
// Module      : stream_capture_slave
// Description : AXI4-Stream sink. Each `start` arms the capture of one packet
//               into a 2^STORAGE_IDX_WIDTH-word buffer. Beats past the buffer
//               depth are drained and flagged as overflow. The buffer can be
//               inspected through a registered random-access read port.
//               Optional macro STREAM_CAPTURE_CHECKSUM_EN builds a running
//               checksum of the stored (masked) words; without it checksum=0.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_capture_slave #(
  parameter int DATA_WIDTH        = 32,
  parameter int STORAGE_IDX_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        S_AXI_TDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_AXI_TKEEP,
  input  logic                         S_AXI_TVALID,
  output logic                         S_AXI_TREADY,
  input  logic                         S_AXI_TLAST,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [STORAGE_IDX_WIDTH:0]   word_count,
  input  logic [STORAGE_IDX_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [DATA_WIDTH-1:0]        checksum
);

  localparam int                     c_num_bytes = DATA_WIDTH / 8;
  localparam int                     c_depth_int = 1 << STORAGE_IDX_WIDTH;
  localparam logic [STORAGE_IDX_WIDTH:0] c_depth = {1'b1, {STORAGE_IDX_WIDTH{1'b0}}};
  localparam logic [STORAGE_IDX_WIDTH:0] c_one   = {{STORAGE_IDX_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [STORAGE_IDX_WIDTH:0] word_count_q, word_count_d;
  logic                       overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]      rd_data_q;
  logic [DATA_WIDTH-1:0]      buffer_mem [0:c_depth_int-1];
  logic [DATA_WIDTH-1:0]      masked_data;
  logic [STORAGE_IDX_WIDTH:0] word_count_inc;
  logic                       handshake;
  logic                       wr_en;
  logic                       capture_arm;

  // Ready is a pure decode of the state register so it never depends on TVALID.
  assign S_AXI_TREADY   = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
  assign busy           = S_AXI_TREADY;
  assign done           = (state_q == ST_DONE);
  assign overflow       = overflow_q;
  assign word_count     = word_count_q;
  assign rd_data        = rd_data_q;

  assign handshake      = S_AXI_TVALID && S_AXI_TREADY;
  assign wr_en          = handshake && (state_q == ST_CAPTURE);
  assign capture_arm    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign word_count_inc = word_count_q + c_one;

  // Zero every byte lane whose TKEEP qualifier is low before it is stored.
  always_comb begin
    masked_data = '0;
    for (int b = 0; b < c_num_bytes; b++) begin
      masked_data[b*8 +: 8] = S_AXI_TKEEP[b] ? S_AXI_TDATA[b*8 +: 8] : 8'h00;
    end
  end

  // Next-state, word counter and overflow flag for the capture sequence.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (capture_arm) begin
          state_d      = ST_CAPTURE;
          word_count_d = '0;
          overflow_d   = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (handshake) begin
          word_count_d = word_count_inc;
          // TLAST wins over the full condition: a packet of exactly DEPTH beats is not an overflow.
          if (S_AXI_TLAST) begin
            state_d = ST_DONE;
          end else if (word_count_inc == c_depth) begin
            state_d    = ST_DRAIN;
            overflow_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (handshake && S_AXI_TLAST) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Capture buffer write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer_mem[word_count_q[STORAGE_IDX_WIDTH-1:0]] <= masked_data;
    end
  end

  // Registered read port; a same-cycle write is seen on the following read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= buffer_mem[rd_addr];
    end
  end

`ifdef STREAM_CAPTURE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // Running modulo-2^DATA_WIDTH sum of the words actually written to the buffer.
  always_comb begin
    checksum_d = checksum_q;
    if (capture_arm) begin
      checksum_d = '0;
    end else if (wr_en) begin
      checksum_d = checksum_q + masked_data;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_capture_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_capture_slave
// Description : Self-checking bench. Two DUT instances (depth 1024 and depth 4)
//               receive identical stream traffic; a packet-level reference
//               model derives stored words, counts, overflow and checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_capture_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        start;

  logic        tready_b, busy_b, done_b, ovf_b;
  logic [10:0] wc_b;
  logic [9:0]  rd_addr_b;
  logic [31:0] rd_data_b, cs_b;

  logic        tready_s, busy_s, done_s, ovf_s;
  logic [2:0]  wc_s;
  logic [1:0]  rd_addr_s;
  logic [31:0] rd_data_s, cs_s;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pkt_data [$];
  logic [3:0]  pkt_keep [$];

  stream_capture_slave #(.DATA_WIDTH(32), .STORAGE_IDX_WIDTH(10)) u_dut_big (
    .clk(clk), .reset(rst_n),
    .S_AXI_TDATA(tdata), .S_AXI_TKEEP(tkeep), .S_AXI_TVALID(tvalid),
    .S_AXI_TREADY(tready_b), .S_AXI_TLAST(tlast), .start(start),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .word_count(wc_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .checksum(cs_b)
  );

  stream_capture_slave #(.DATA_WIDTH(32), .STORAGE_IDX_WIDTH(2)) u_dut_small (
    .clk(clk), .reset(rst_n),
    .S_AXI_TDATA(tdata), .S_AXI_TKEEP(tkeep), .S_AXI_TVALID(tvalid),
    .S_AXI_TREADY(tready_s), .S_AXI_TLAST(tlast), .start(start),
    .busy(busy_s), .done(done_s), .overflow(ovf_s), .word_count(wc_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data_s), .checksum(cs_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte lanes with a cleared keep bit are stored as zero.
  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] r;
    r = d;
    for (int b = 0; b < 4; b++) if (!k[b]) r[b*8 +: 8] = 8'h00;
    return r;
  endfunction

  task automatic push_beat(input logic [31:0] d, input logic [3:0] k);
    pkt_data.push_back(d);
    pkt_keep.push_back(k);
  endtask

  task automatic clear_pkt();
    pkt_data.delete();
    pkt_keep.delete();
  endtask

  task automatic do_start(input string name);
    tvalid = 1'b0;
    tlast  = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    check_value({name, "/start_tready_b"}, tready_b, 1);
    check_value({name, "/start_tready_s"}, tready_s, 1);
    check_value({name, "/start_busy_b"}, busy_b, 1);
    check_value({name, "/start_done_b"}, done_b, 0);
    check_value({name, "/start_wc_b"}, wc_b, 0);
    check_value({name, "/start_wc_s"}, wc_s, 0);
    check_value({name, "/start_ovf_s"}, ovf_s, 0);
    check_value({name, "/start_cs_b"}, cs_b, 0);
  endtask

  task automatic send_packet(input string name, input bit gaps, input bit mid_start);
    int n;
    n = pkt_data.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        tvalid = 1'b0;
        tdata  = $urandom;
        tkeep  = 4'hF;
        tlast  = 1'($urandom_range(0, 1));
        start  = mid_start && ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        start  = 1'b0;
      end
      tvalid = 1'b1;
      tdata  = pkt_data[i];
      tkeep  = pkt_keep[i];
      tlast  = (i == n - 1);
      start  = mid_start && ($urandom_range(0, 3) == 0);
      if (i < 3 || i == n - 1) begin
        check_value({name, "/beat_tready_b"}, tready_b, 1);
        check_value({name, "/beat_tready_s"}, tready_s, 1);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Packet-level model: first min(n, DEPTH) masked beats are stored, the rest dropped.
  task automatic check_result(input string name);
    int          n, st_b, st_s, last_i;
    logic [31:0] sum_b, sum_s, m;
    n     = pkt_data.size();
    st_b  = (n < 1024) ? n : 1024;
    st_s  = (n < 4) ? n : 4;
    sum_b = '0;
    sum_s = '0;
    for (int i = 0; i < n; i++) begin
      m = mask_word(pkt_data[i], pkt_keep[i]);
      if (i < st_b) sum_b = sum_b + m;
      if (i < st_s) sum_s = sum_s + m;
    end
`ifndef STREAM_CAPTURE_CHECKSUM_EN
    sum_b = '0;
    sum_s = '0;
`endif
    check_value({name, "/done_b"}, done_b, 1);
    check_value({name, "/done_s"}, done_s, 1);
    check_value({name, "/busy_b"}, busy_b, 0);
    check_value({name, "/busy_s"}, busy_s, 0);
    check_value({name, "/tready_b"}, tready_b, 0);
    check_value({name, "/wc_b"}, wc_b, 64'(st_b));
    check_value({name, "/wc_s"}, wc_s, 64'(st_s));
    check_value({name, "/ovf_b"}, ovf_b, (n > 1024) ? 1 : 0);
    check_value({name, "/ovf_s"}, ovf_s, (n > 4) ? 1 : 0);
    check_value({name, "/cs_b"}, cs_b, sum_b);
    check_value({name, "/cs_s"}, cs_s, sum_s);
    last_i = st_b;
    for (int i = 0; i < last_i; i++) begin
      rd_addr_b = i[9:0];
      if (i < st_s) rd_addr_s = i[1:0];
      @(posedge clk); #1;
      check_value({name, "/rd_b"}, rd_data_b, mask_word(pkt_data[i], pkt_keep[i]));
      if (i < st_s) check_value({name, "/rd_s"}, rd_data_s, mask_word(pkt_data[i], pkt_keep[i]));
    end
    check_value({name, "/done_hold_b"}, done_b, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    tdata     = '0;
    tkeep     = '0;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    start     = 1'b0;
    rd_addr_b = '0;
    rd_addr_s = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_value("rst/tready_b", tready_b, 0);
    check_value("rst/busy_b", busy_b, 0);
    check_value("rst/done_b", done_b, 0);
    check_value("rst/ovf_b", ovf_b, 0);
    check_value("rst/wc_b", wc_b, 0);
    check_value("rst/rd_data_b", rd_data_b, 0);
    check_value("rst/cs_b", cs_b, 0);
    check_value("rst/tready_s", tready_s, 0);
    check_value("rst/rd_data_s", rd_data_s, 0);
    rst_n = 1'b1;

    // Traffic before any start is never accepted
    tvalid = 1'b1;
    tdata  = 32'h5;
    tkeep  = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
      check_value("prestart/tready_b", tready_b, 0);
      check_value("prestart/wc_b", wc_b, 0);
      check_value("prestart/done_b", done_b, 0);
    end
    tvalid = 1'b0;

    // Four-beat packet; exactly DEPTH beats for the small instance
    clear_pkt();
    push_beat(32'h11, 4'hF); push_beat(32'h22, 4'hF);
    push_beat(32'h33, 4'hF); push_beat(32'h44, 4'hF);
    do_start("pkt4");
    send_packet("pkt4", 1'b0, 1'b0);
    check_result("pkt4");
    rd_addr_b = 10'd2;
    @(posedge clk); #1;
    check_value("pkt4/rd_addr2", rd_data_b, 32'h33);

    // Keep masking
    clear_pkt();
    push_beat(32'hDEADBEEF, 4'b0011);
    do_start("keep");
    send_packet("keep", 1'b0, 1'b0);
    check_result("keep");

    // Six beats: overflow on the small instance
    clear_pkt();
    for (int i = 1; i <= 6; i++) push_beat(32'(i), 4'hF);
    do_start("ovf6");
    send_packet("ovf6", 1'b0, 1'b0);
    check_result("ovf6");

    // Gaps plus an ignored mid-packet start
    clear_pkt();
    push_beat(32'hA1, 4'hF); push_beat(32'hB2, 4'hF); push_beat(32'hC3, 4'hF);
    do_start("gaps");
    tvalid = 1'b1; tdata = pkt_data[0]; tkeep = 4'hF; tlast = 1'b0;
    @(posedge clk); #1;
    tvalid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tvalid = 1'b1; tdata = pkt_data[1];
    @(posedge clk); #1;
    tvalid = 1'b0; tdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check_value("gaps/wc_mid_b", wc_b, 2);
    tvalid = 1'b1; tdata = pkt_data[2]; tlast = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    check_result("gaps");

    // Reset in the middle of a packet
    clear_pkt();
    do_start("rstmid");
    for (int i = 0; i < 2; i++) begin
      tvalid = 1'b1; tdata = 32'h100 + 32'(i); tkeep = 4'hF; tlast = 1'b0;
      @(posedge clk); #1;
    end
    tdata = 32'h102;
    #2;
    rst_n = 1'b0;
    #1;
    check_value("rstmid/tready_b", tready_b, 0);
    check_value("rstmid/busy_b", busy_b, 0);
    check_value("rstmid/tready_s", tready_s, 0);
    check_value("rstmid/wc_b", wc_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 3; i < 5; i++) begin
      tdata = 32'h100 + 32'(i);
      tlast = (i == 4);
      @(posedge clk); #1;
      check_value("rstmid/after_tready_b", tready_b, 0);
      check_value("rstmid/after_wc_b", wc_b, 0);
      check_value("rstmid/after_done_b", done_b, 0);
    end
    tvalid = 1'b0; tlast = 1'b0;
    push_beat(32'h77, 4'hF);
    do_start("rstmid77");
    send_packet("rstmid77", 1'b0, 1'b0);
    check_result("rstmid77");

    // Depth boundary on the large instance
    clear_pkt();
    for (int i = 0; i < 1024; i++) push_beat($urandom, 4'hF);
    do_start("full1024");
    send_packet("full1024", 1'b0, 1'b0);
    check_result("full1024");

    clear_pkt();
    for (int i = 0; i < 1027; i++) push_beat($urandom, 4'($urandom_range(0, 15)));
    do_start("ovf1027");
    send_packet("ovf1027", 1'b1, 1'b1);
    check_result("ovf1027");

    // Randomized packets
    for (int p = 0; p < 25; p++) begin
      int len;
      clear_pkt();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        push_beat($urandom, ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)));
      end
      do_start("rand");
      send_packet("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_result("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
